// File: rtl/press_event_pkg.sv
// Shared state encoding and default timing constants for the press event decoder.
`timescale 1ns/1ps
package press_event_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  localparam int DEF_LONG_CYCLES   = 8;
  localparam int DEF_GAP_CYCLES    = 6;
  localparam int DEF_REPEAT_CYCLES = 4;
  localparam int DEF_CNT_W         = 4;
endpackage

// File: rtl/press_event_decoder_if.sv
// Button level in, event pulses and debug state out; the decoder takes the slave side.
`timescale 1ns/1ps
interface press_event_decoder_if;
  import press_event_pkg::*;

  logic               named_in;
  logic               short_press;
  logic               double_press;
  logic               long_press;
  logic               repeat_pulse;
  logic               held;
  logic [STATE_W-1:0] state_out;

  modport master (
    output named_in,
    input  short_press, double_press, long_press, repeat_pulse, held, state_out
  );

  modport slave (
    input  named_in,
    output short_press, double_press, long_press, repeat_pulse, held, state_out
  );
endinterface

// File: rtl/press_cycle_timer.sv
// Saturating cycle counter with clear, load-1, increment and an equality flag against a limit.
// Count updates on the clock edge; eq is combinational from the current count.
`timescale 1ns/1ps
module press_cycle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld1,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             eq
);
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (ld1) cnt <= CNT_W'(1);
    else if (inc) cnt <= sat_inc(cnt);
  end

  assign eq = (cnt == limit);
endmodule

// File: rtl/press_event_decoder.sv
// Turns a debounced button level into 1-cycle short/double/long events; auto-repeat with PRESS_REPEAT_EN.
// All outputs registered, visible the cycle after the deciding edge; no backpressure, input sampled every cycle.
`timescale 1ns/1ps
module press_event_decoder
  import press_event_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  press_event_decoder_if.slave bus
);
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state, nxt;
  logic             prev_in;
  logic             t_clr, t_ld1, t_inc, t_eq;
  logic [CNT_W-1:0] t_lim;
  logic             sp_n, dp_n, lp_n;
  logic             sp_q, dp_q, lp_q, held_q;
`ifdef PRESS_REPEAT_EN
  logic             rp_n, rp_q;
`endif

  press_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (t_clr),
    .ld1   (t_ld1),
    .inc   (t_inc),
    .limit (t_lim),
    .eq    (t_eq)
  );

  always_comb begin
    case (state)
      WAIT2:     t_lim = GAP_LIM;
      LONG_HOLD: t_lim = REP_LIM;
      default:   t_lim = LONG_LIM;
    endcase
  end

  always_comb begin
    nxt   = state;
    t_clr = 1'b0;
    t_ld1 = 1'b0;
    t_inc = 1'b0;
    sp_n  = 1'b0;
    dp_n  = 1'b0;
    lp_n  = 1'b0;
`ifdef PRESS_REPEAT_EN
    rp_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!prev_in && bus.named_in) begin
          nxt   = PRESS1;
          t_ld1 = 1'b1;
        end
      end
      PRESS1: begin
        if (!bus.named_in) begin
          nxt   = WAIT2;
          t_ld1 = 1'b1;
        end else if (t_eq) begin
          nxt   = LONG_HOLD;
          lp_n  = 1'b1;
          t_clr = 1'b1;
        end else begin
          t_inc = 1'b1;
        end
      end
      WAIT2: begin
        if (bus.named_in) begin
          nxt   = PRESS2;
          t_ld1 = 1'b1;
        end else if (t_eq) begin
          nxt  = IDLE;
          sp_n = 1'b1;
        end else begin
          t_inc = 1'b1;
        end
      end
      PRESS2: begin
        // A second press that turns into a long hold drops the pending double.
        if (!bus.named_in) begin
          nxt  = IDLE;
          dp_n = 1'b1;
        end else if (t_eq) begin
          nxt   = LONG_HOLD;
          lp_n  = 1'b1;
          t_clr = 1'b1;
        end else begin
          t_inc = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (!bus.named_in) begin
          nxt = IDLE;
        end else begin
`ifdef PRESS_REPEAT_EN
          if (t_eq) begin
            rp_n  = 1'b1;
            t_clr = 1'b1;
          end else begin
            t_inc = 1'b1;
          end
`else
          t_inc = 1'b1;
`endif
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // prev_in resets high so a button already down at reset release is not a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      prev_in <= 1'b1;
      sp_q    <= 1'b0;
      dp_q    <= 1'b0;
      lp_q    <= 1'b0;
      held_q  <= 1'b0;
`ifdef PRESS_REPEAT_EN
      rp_q    <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      prev_in <= bus.named_in;
      sp_q    <= sp_n;
      dp_q    <= dp_n;
      lp_q    <= lp_n;
      held_q  <= (nxt == LONG_HOLD);
`ifdef PRESS_REPEAT_EN
      rp_q    <= rp_n;
`endif
    end
  end

  assign bus.short_press  = sp_q;
  assign bus.double_press = dp_q;
  assign bus.long_press   = lp_q;
  assign bus.held         = held_q;
  assign bus.state_out    = state;
`ifdef PRESS_REPEAT_EN
  assign bus.repeat_pulse = rp_q;
`else
  assign bus.repeat_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_press_event_decoder.sv
// Directed bench for press_event_decoder: event timing, holds, double/long priority and async reset abort.
`timescale 1ns/1ps
module tb_press_event_decoder;
  import press_event_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #2 clk = ~clk;

  press_event_decoder_if bus();

  press_event_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int samp;
  int n_sp, n_dp, n_lp, n_rp, n_held, n_multi, n_nonidle;
  int pos_sp, pos_dp, pos_lp, pos_rp;
  logic held_hist [0:63];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    samp = 0; n_sp = 0; n_dp = 0; n_lp = 0; n_rp = 0;
    n_held = 0; n_multi = 0; n_nonidle = 0;
    pos_sp = 0; pos_dp = 0; pos_lp = 0; pos_rp = 0;
    for (int i = 0; i < 64; i++) held_hist[i] = 1'b0;
  endtask

  // Drive one input sample, then observe the registered result just after the edge.
  task automatic apply(input logic v);
    int pulses;
    bus.named_in = v;
    @(posedge clk);
    #1;
    samp++;
    pulses = 0;
    if (bus.short_press)  begin n_sp++; pulses++; if (pos_sp == 0) pos_sp = samp; end
    if (bus.double_press) begin n_dp++; pulses++; if (pos_dp == 0) pos_dp = samp; end
    if (bus.long_press)   begin n_lp++; pulses++; if (pos_lp == 0) pos_lp = samp; end
    if (bus.repeat_pulse) begin n_rp++; pulses++; if (pos_rp == 0) pos_rp = samp; end
    if (bus.held) n_held++;
    if (pulses > 1) n_multi++;
    if (bus.state_out != 3'd0) n_nonidle++;
    if (samp < 64) held_hist[samp] = bus.held;
  endtask

  task automatic run(input logic v, input int n);
    for (int i = 0; i < n; i++) apply(v);
  endtask

  initial begin
    bus.named_in = 1'b1;
    reset = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(bus.state_out), 0);
    chk("rst_pulses", int'({bus.short_press, bus.double_press, bus.long_press, bus.repeat_pulse}), 0);
    chk("rst_held", int'(bus.held), 0);
    reset = 1'b1;

    // Button already down at reset release must not register.
    clear_counts();
    run(1'b1, 20);
    chk("t1_pulses", n_sp + n_dp + n_lp + n_rp, 0);
    chk("t1_nonidle", n_nonidle, 0);
    run(1'b0, 2);

    // Short press.
    clear_counts();
    apply(1'b1);
    chk("t2_state_press1", int'(bus.state_out), 1);
    run(1'b1, 2);
    apply(1'b0);
    chk("t2_state_wait2", int'(bus.state_out), 2);
    run(1'b0, 9);
    chk("t2_short_cnt", n_sp, 1);
    chk("t2_short_pos", pos_sp, 9);
    chk("t2_others", n_dp + n_lp + n_rp, 0);

    // Double press.
    clear_counts();
    run(1'b1, 3);
    run(1'b0, 2);
    run(1'b1, 2);
    chk("t3_state_press2", int'(bus.state_out), 3);
    run(1'b0, 8);
    chk("t3_double_cnt", n_dp, 1);
    chk("t3_double_pos", pos_dp, 8);
    chk("t3_short_cnt", n_sp, 0);

    // Long hold.
    clear_counts();
    run(1'b1, 20);
    chk("t4_long_cnt", n_lp, 1);
    chk("t4_long_pos", pos_lp, 8);
    chk("t4_held_before", int'(held_hist[7]), 0);
    chk("t4_held_at_long", int'(held_hist[8]), 1);
    chk("t4_held_cycles", n_held, 13);
    chk("t4_state_hold", int'(bus.state_out), 4);
`ifdef PRESS_REPEAT_EN
    chk("t4_repeat_cnt", n_rp, 3);
    chk("t4_repeat_pos", pos_rp, 12);
`else
    chk("t4_repeat_cnt", n_rp, 0);
`endif
    apply(1'b0);
    chk("t4_held_release", int'(bus.held), 0);
    chk("t4_state_release", int'(bus.state_out), 0);
    run(1'b0, 3);
    chk("t4_release_events", n_sp + n_dp + n_lp, 1);

    // Second press held long: only long_press, nothing on release.
    clear_counts();
    run(1'b1, 3);
    run(1'b0, 2);
    run(1'b1, 10);
    run(1'b0, 8);
    chk("t5_long_cnt", n_lp, 1);
    chk("t5_long_pos", pos_lp, 13);
    chk("t5_short_dbl", n_sp + n_dp, 0);
    chk("t5_multi", n_multi, 0);

    // One-cycle toggles still count as press/release.
    clear_counts();
    apply(1'b1);
    apply(1'b0);
    apply(1'b1);
    apply(1'b0);
    run(1'b0, 6);
    chk("tog_double_pos", pos_dp, 4);
    chk("tog_short_cnt", n_sp, 0);

    // Reset during WAIT2 aborts the pending short press.
    clear_counts();
    run(1'b1, 3);
    run(1'b0, 2);
    chk("t6_state_wait2", int'(bus.state_out), 2);
    reset = 1'b0;
    #1;
    chk("t6_state_rst", int'(bus.state_out), 0);
    chk("t6_outs_rst", int'({bus.short_press, bus.double_press, bus.long_press, bus.repeat_pulse, bus.held}), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_counts();
    run(1'b0, 10);
    chk("t6_no_short", n_sp, 0);
    chk("t6_no_events", n_dp + n_lp + n_rp, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
